// File: rtl/enemy_sprite_pkg.sv
// Shared constants for the enemy sprite plotter: screen size, colour codes,
// pose encodings and the built-in sprite sheet image.
package enemy_sprite_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BG_COLOUR_DEF   = 3'b000;
  localparam logic [2:0] TRANSPARENT_DEF = 3'b101;
  localparam logic [2:0] COL_RED         = 3'b100;
  localparam logic [2:0] COL_YELLOW      = 3'b110;
  localparam logic [2:0] COL_GREEN       = 3'b010;
  localparam logic [2:0] COL_BLUE        = 3'b001;

  typedef enum logic [1:0] {
    POSE_IDLE    = 2'd0,
    POSE_PUNCH_L = 2'd1,
    POSE_PUNCH_R = 2'd2,
    POSE_BLOCK   = 2'd3
  } pose_e;

  // The block pose has one see-through row, so the background shows through it.
  localparam logic [4:0] BLOCK_GAP_ROW = 5'd7;

  // Sprite sheet image, address = {pose[1:0], row[4:0], col[4:0]}.
  function automatic logic [2:0] sprite_texel(input logic [11:0] addr);
    logic [2:0] c;
    case (pose_e'(addr[11:10]))
      POSE_IDLE:    c = COL_RED;
      POSE_PUNCH_L: c = COL_YELLOW;
      POSE_PUNCH_R: c = COL_GREEN;
      default:      c = (addr[9:5] == BLOCK_GAP_ROW) ? TRANSPARENT_DEF : COL_BLUE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/enemy_sprite_rom.sv
// Sprite sheet ROM with one-cycle registered read; contents come from the
// package sprite image.
module enemy_sprite_rom
  import enemy_sprite_pkg::*;
(
  input  logic        clock,
  input  logic [11:0] address,
  output logic [2:0]  colour
);

  always_ff @(posedge clock) colour <= sprite_texel(address);

endmodule

// File: rtl/enemy_sprite_plotter.sv
// Erases the previous enemy box, then draws the selected pose at the new
// position, one pixel per cycle to the VGA adapter with screen clipping.
module enemy_sprite_plotter
  import enemy_sprite_pkg::*;
#(
  parameter int         SPRITE_W    = 32,
  parameter int         SPRITE_H    = 32,
  parameter logic [2:0] BG_COLOUR   = BG_COLOUR_DEF,
  parameter logic [2:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] pose,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       plot_finished
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int NW = CW + RW;

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [1:0]    pose_q;
  logic [7:0]    x_q, prev_x_q;
  logic [6:0]    y_q, prev_y_q;
  logic          prev_valid_q;
  logic          accept, commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        accept  = 1'b1;
        cnt_d   = '0;
        state_d = prev_valid_q ? S_ERASE : S_DRAW;
      end
      S_ERASE: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_DRAW;
      end
      S_DRAW: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ERASE and DRAW walk the same row/col counter; only the box origin differs.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [8:0]    px;
  logic [7:0]    py;
  logic          pix_vld_d, pix_inb_d;
  logic [11:0]   rom_addr;
  logic [2:0]    rom_colour;

  assign col       = cnt_q[CW-1:0];
  assign row       = cnt_q[NW-1:CW];
  assign pix_vld_d = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign base_x    = (state_q == S_ERASE) ? prev_x_q : x_q;
  assign base_y    = (state_q == S_ERASE) ? prev_y_q : y_q;
  assign px        = {1'b0, base_x} + 9'(col);
  assign py        = {1'b0, base_y} + 8'(row);
  assign pix_inb_d = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  assign rom_addr  = 12'({pose_q, cnt_q});

  enemy_sprite_rom u_rom (
    .clock   (clock),
    .address (rom_addr),
    .colour  (rom_colour)
  );

  logic       pix_vld_q, pix_draw_q, pix_inb_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pose_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      pix_vld_q    <= 1'b0;
      pix_draw_q   <= 1'b0;
      pix_inb_q    <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pose_q <= pose;
        x_q    <= pos_x;
        y_q    <= pos_y;
      end
      if (commit) begin
        prev_valid_q <= 1'b1;
        prev_x_q     <= x_q;
        prev_y_q     <= y_q;
      end
      pix_vld_q  <= pix_vld_d;
      pix_draw_q <= (state_q == S_DRAW);
      pix_inb_q  <= pix_vld_d & pix_inb_d;
      vga_x_q    <= pix_vld_d ? px[7:0] : '0;
      vga_y_q    <= pix_vld_d ? py[6:0] : '0;
    end
  end

  // The ROM output register has no reset, so it is gated by the pixel valid bit.
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = pix_vld_q ? (pix_draw_q ? rom_colour : BG_COLOUR) : '0;
  assign vga_plot      = pix_vld_q & pix_inb_q & (~pix_draw_q | (rom_colour != TRANSPARENT));
  assign busy          = (state_q != S_IDLE);
  assign plot_finished = (state_q == S_DONE);

endmodule

// File: doc/enemy_sprite_plotter.md
ENEMY_SPRITE_PLOTTER -- requirements
Module: enemy_sprite_plotter

Interface
REQ-001 Parameter SPRITE_W, 32, sprite width in pixels (power of two).
REQ-002 Parameter SPRITE_H, 32, sprite height in pixels (power of two).
REQ-003 Parameter BG_COLOUR, 3'b000, colour written during erase.
REQ-004 Parameter TRANSPARENT, 3'b101, sprite ROM colour that is never plotted.
REQ-005 Port: clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: start  input  1  request to redraw the enemy, level-sampled, driven by the meta-controller's writeEn.
REQ-008 Port: pose  input  2  sprite select: 0 idle, 1 punch-left, 2 punch-right, 3 block.
REQ-009 Port: pos_x  input  8  top-left X of the new sprite box.
REQ-010 Port: pos_y  input  7  top-left Y of the new sprite box.
REQ-011 Port: vga_x  output  8  pixel X to the VGA adapter.
REQ-012 Port: vga_y  output  7  pixel Y to the VGA adapter.
REQ-013 Port: vga_colour  output  3  pixel colour.
REQ-014 Port: vga_plot  output  1  write strobe; the pixel is valid only while high.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: plot_finished  output  1  single-cycle completion pulse, consumed by the meta-controller.

Function
REQ-017 FSM states SHALL be IDLE, ERASE, DRAW, DRAIN, and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch pose/pos_x/pos_y and go to ERASE if prev_valid=1, else to DRAW; start SHALL be ignored outside IDLE.
REQ-019 ERASE SHALL scan the previous box row-major (col fastest) for SPRITE_W*SPRITE_H cycles, with one pixel per cycle, colour BG_COLOUR, and vga_plot=1 subject to clipping (REQ-023), then enter DRAW.
REQ-020 DRAW SHALL issue one ROM address per cycle, address = {pose, row, col}, for SPRITE_W*SPRITE_H cycles, then enter DRAIN.
REQ-021 The ROM SHALL have one-cycle read latency.
REQ-022 The vga_x, vga_y, vga_colour, and vga_plot outputs SHALL be registered one cycle behind the address, so the last pixel appears in DRAIN.
REQ-023 The pixel coordinates SHALL be x = pos_x + col and y = pos_y + row, computed one bit wider than the port.
REQ-024 A pixel with x ≥ 160 or y ≥ 120 SHALL have vga_plot=0, with no wrap-around.
REQ-025 A DRAW pixel whose ROM colour equals TRANSPARENT SHALL have vga_plot=0.
REQ-026 In DONE, the block SHALL assert plot_finished for exactly one cycle, copy the latched position into prev_x/prev_y, set prev_valid=1, and return to IDLE.
REQ-027 Latency from the start-accept edge to plot_finished SHALL be 2*N+2 cycles with erase and N+2 cycles without erase, where N = SPRITE_W*SPRITE_H.
REQ-028 A change on pose/pos_x/pos_y while busy SHALL have no effect until the next accept.
REQ-029 start held high through DONE SHALL cause re-acceptance on the first IDLE cycle.
REQ-030 vga_plot SHALL be 0 in IDLE and DONE.

Reset
REQ-031 Assertion of reset_n=0, at any time including mid-ERASE/DRAW, SHALL immediately force state IDLE and counters 0.
REQ-032 During reset, prev_valid, prev_x, and prev_y SHALL be 0.
REQ-033 During reset, vga_x, vga_y, vga_colour, vga_plot, busy, and plot_finished SHALL be 0.
REQ-034 The first start after reset SHALL skip ERASE.

Structure
REQ-035 A shared constants include SHALL hold the screen dimensions (160, 120), the colour codes (BG_COLOUR, TRANSPARENT), and the pose encodings.
REQ-036 The FSM state codes SHALL remain local to the module.
REQ-037 The ROM SHALL be a sub-module named enemy_sprite_rom with ports clock, address[11:0], and colour[2:0], initialised from a memory file.
REQ-038 The ERASE and DRAW phases SHALL share one row/col counter pair.

Verification
REQ-039 Reset, then start with pose=0, pos=(10,20), and an all-red ROM -> no ERASE, 1024 plots covering x 10..41 and y 20..51 in row-major order, and plot_finished exactly 1026 cycles after accept.
REQ-040 A second start with pos=(50,20) -> 1024 BG_COLOUR plots at the old box, then the new box, and plot_finished after 2050 cycles.
REQ-041 pos=(150,110) -> only pixels with x 150..159 and y 110..119 plotted (100 pixels), with no plots at wrapped coordinates.
REQ-042 A ROM row of TRANSPARENT at pose=3 -> the corresponding 32 pixels are never strobed, and all others are plotted.
REQ-043 reset_n pulsed low at DRAW cycle 500 -> outputs are 0 within the same cycle, and the next start skips ERASE.
REQ-044 start held high continuously -> back-to-back redraws with exactly one IDLE cycle between DONE and ERASE, and one plot_finished pulse per redraw.
